// File: rtl/aes_round_pkg.sv
// Shared types and GF(2^8) helpers for the AES encryption round engine.
// GF arithmetic uses the AES field polynomial 0x11B.
package aes_round_pkg;

    localparam int AES_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SBOX,
        MAIN,
        DONE
    } round_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    // Word c of the result takes row r from input word (c + r) mod 4.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = s;
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// Combinational AES MixColumns over a full 128-bit state.
module aes_mixcolumns
    import aes_round_pkg::*;
(
    input  logic [127:0] block,
    output logic [127:0] mixed
);

    assign mixed = mixcolumns(block);

endmodule

// File: rtl/aes_enc_round_lanes.sv
// AES encryption round with SubBytes time-multiplexed over an external S-box bank.
// Optional feature macro: AES_ROUND_FINAL_EN (honour final_round, skipping MixColumns).
module aes_enc_round_lanes
    import aes_round_pkg::*;
#(
    parameter int NUM_LANES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           block_i,
    input  logic [127:0]           round_key,
    input  logic                   final_round,
    output logic [32*NUM_LANES-1:0] sboxw_i,
    input  logic [32*NUM_LANES-1:0] sboxw_o,
    output logic [127:0]           block_o,
    output logic                   out_valid,
    input  logic                   out_ready
);

    if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_lanes
        $error("aes_enc_round_lanes: NUM_LANES must be 1, 2 or 4");
    end

    localparam int         STEPS     = AES_WORDS / NUM_LANES;
    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

    round_state_t state_q;
    logic [1:0]   step_ctr;
    logic [127:0] blk_q;
    logic [127:0] key_q;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] round_out;
    logic         accept;

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign block_o  = blk_q;
    assign shifted  = shiftrows(blk_q);

    aes_mixcolumns u_mix (
        .block (shifted),
        .mixed (mixed)
    );

`ifdef AES_ROUND_FINAL_EN
    logic mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mode_q <= 1'b0;
        else if (accept)
            mode_q <= final_round;
    end

    assign round_out = (mode_q ? shifted : mixed) ^ key_q;
`else
    logic unused_final_round;

    assign unused_final_round = final_round;
    assign round_out          = mixed ^ key_q;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        sboxw_i = '0;
        if (state_q == SBOX) begin
            for (int k = 0; k < NUM_LANES; k++)
                sboxw_i[32*(NUM_LANES-k)-1 -: 32] =
                    blk_q[127-32*(int'(step_ctr)*NUM_LANES+k) -: 32];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            step_ctr  <= '0;
            blk_q     <= '0;
            key_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        blk_q     <= block_i;
                        key_q     <= round_key;
                        step_ctr  <= '0;
                        out_valid <= 1'b0;
                        state_q   <= SBOX;
                    end else if (state_q == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                SBOX: begin
                    for (int k = 0; k < NUM_LANES; k++)
                        blk_q[127-32*(int'(step_ctr)*NUM_LANES+k) -: 32] <=
                            sboxw_o[32*(NUM_LANES-k)-1 -: 32];
                    step_ctr <= step_ctr + 2'd1;
                    if (step_ctr == LAST_STEP)
                        state_q <= MAIN;
                end
                MAIN: begin
                    blk_q     <= round_out;
                    out_valid <= 1'b1;
                    state_q   <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_round_lanes.sv
// Scoreboard bench for aes_enc_round_lanes with NUM_LANES = 1, 2 and 4 side by side.
// Each instance gets its own behavioural S-box bank; expected rounds come from an independent byte-level model.
`timescale 1ns/1ps
module tb_aes_enc_round_lanes;

    localparam logic [0:2047] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid    [3];
    logic         in_ready    [3];
    logic         final_round [3];
    logic         out_valid   [3];
    logic         out_ready   [3];
    logic [127:0] block_i     [3];
    logic [127:0] round_key   [3];
    logic [127:0] block_o     [3];
    logic [127:0] sbw_mon     [3];

    int           vectors     = 0;
    int           miscompares = 0;
    logic [127:0] exp_q[$];
    int           cur = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_TBL[int'(b)*8 +: 8];
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        logic [7:0] r;
        r = {b[6:0], 1'b0};
        if (b[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    // Byte-level reference round; byte i sits at row i%4, column i/4.
    function automatic logic [127:0] ref_round(input logic [127:0] blk, input logic [127:0] key, input logic fin);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   m [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        logic         skip_mix;
`ifdef AES_ROUND_FINAL_EN
        skip_mix = fin;
`else
        skip_mix = 1'b0 & fin;
`endif
        for (int i = 0; i < 16; i++) s[i] = sb(blk[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = s[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            m[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
            m[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
            m[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
            m[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end
        for (int i = 0; i < 16; i++)
            res[127-8*i -: 8] = (skip_mix ? t[i] : m[i]) ^ key[127-8*i -: 8];
        return res;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NL = 1 << g;
        logic [32*NL-1:0] sbw_i;
        logic [32*NL-1:0] sbw_o;

        always_comb begin
            sbw_o = '0;
            for (int k = 0; k < 4*NL; k++) sbw_o[8*k +: 8] = sb(sbw_i[8*k +: 8]);
        end

        assign sbw_mon[g] = 128'(sbw_i);

        aes_enc_round_lanes #(.NUM_LANES(NL)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .block_i     (block_i[g]),
            .round_key   (round_key[g]),
            .final_round (final_round[g]),
            .sboxw_i     (sbw_i),
            .sboxw_o     (sbw_o),
            .block_o     (block_o[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid[cur] && out_ready[cur]) begin
            if (exp_q.size() == 0)
                check("unexpected_output", 128'd1, 128'd0);
            else
                check($sformatf("result_lanes%0d", 1 << cur), block_o[cur], exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block, wait for acceptance, then scramble the inputs.
    task automatic send(input int idx, input logic [127:0] blk, input logic [127:0] key, input logic fin);
        int n;
        block_i[idx]     = blk;
        round_key[idx]   = key;
        final_round[idx] = fin;
        in_valid[idx]    = 1'b1;
        n = 0;
        while (!in_ready[idx] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 128'd1, 128'd0);
        @(posedge clk);
        exp_q.push_back(ref_round(blk, key, fin));
        #1;
        in_valid[idx]    = 1'b0;
        block_i[idx]     = ~blk;
        round_key[idx]   = ~key;
        final_round[idx] = ~fin;
    endtask

    // Count edges from the accept edge until out_valid rises.
    task automatic wait_out(input int idx, input string tag);
        int n;
        n = 0;
        while (!out_valid[idx] && n < 50) begin
            tick();
            n++;
        end
        check(tag, 128'(n), 128'((4 >> idx) + 1));
    endtask

    initial begin
        logic [127:0] fips_in, fips_key, fips_out, fin_in, fin_key, fin_out;
        logic [127:0] blk_a, blk_b, blk_c, blk_d, key_a, key_b, exp_c;
        logic         fin_r;

        fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        fips_key = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_out = 128'ha49c7ff2689f352b6b5bea43026a5049;
        fin_in   = 128'heb598b1b402ea1c3f23813421e84e7d2;
        fin_key  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        fin_out  = 128'h3925841d02dc09fbdc118597196a0b32;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1; final_round[i] = 1'b0;
            block_i[i] = '0; round_key[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_out_valid", 128'(out_valid[i]), 128'd0);
            check("reset_block_o", block_o[i], 128'd0);
            check("reset_in_ready", 128'(in_ready[i]), 128'd1);
            check("reset_sboxw_i", sbw_mon[i], 128'd0);
        end
        reset = 1'b0;
        tick();

        // FIPS-197 round 1 on every lane count, with inputs scrambled after acceptance.
        for (int i = 0; i < 3; i++) begin
            cur = i;
            send(i, fips_in, fips_key, 1'b0);
            wait_out(i, "fips_latency");
            check("fips_known_answer", block_o[i], fips_out);
            tick();
        end

        // Final round vector.
        cur = 1;
        send(1, fin_in, fin_key, 1'b1);
        wait_out(1, "final_latency");
`ifdef AES_ROUND_FINAL_EN
        check("final_known_answer", block_o[1], fin_out);
`else
        check("final_ignored", 128'(block_o[1] != fin_out), 128'd1);
`endif
        tick();

        // Back-to-back: second accept on the first output handshake edge.
        for (int i = 0; i < 3; i += 2) begin
            cur   = i;
            blk_a = {$urandom, $urandom, $urandom, $urandom};
            blk_b = {$urandom, $urandom, $urandom, $urandom};
            key_a = {$urandom, $urandom, $urandom, $urandom};
            key_b = {$urandom, $urandom, $urandom, $urandom};
            block_i[i] = blk_a; round_key[i] = key_a; final_round[i] = 1'b0; in_valid[i] = 1'b1;
            @(posedge clk);
            exp_q.push_back(ref_round(blk_a, key_a, 1'b0));
            #1;
            block_i[i] = blk_b; round_key[i] = key_b;
            wait_out(i, "b2b_first_latency");
            check("b2b_in_ready_in_done", 128'(in_ready[i]), 128'd1);
            @(posedge clk);
            exp_q.push_back(ref_round(blk_b, key_b, 1'b0));
            #1;
            check("b2b_second_accepted", 128'({out_valid[i], in_ready[i]}), 128'd0);
            in_valid[i] = 1'b0; block_i[i] = ~blk_b; round_key[i] = ~key_b;
            wait_out(i, "b2b_second_latency");
            tick();
        end

        // Stall: out_ready low for 10 cycles with a competing input offered.
        cur   = 1;
        blk_c = {$urandom, $urandom, $urandom, $urandom};
        exp_c = ref_round(blk_c, fips_key, 1'b0);
        out_ready[1] = 1'b0;
        send(1, blk_c, fips_key, 1'b0);
        wait_out(1, "stall_latency");
        in_valid[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            block_i[1] = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("stall_out_valid", 128'(out_valid[1]), 128'd1);
            check("stall_block_o", block_o[1], exp_c);
            check("stall_in_ready", 128'(in_ready[1]), 128'd0);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        tick();
        check("stall_release_idle", 128'({out_valid[1], in_ready[1]}), 128'b01);
        repeat (6) tick();
        check("stall_no_extra_round", 128'(out_valid[1]), 128'd0);

        // Reset in SBOX step 1, then a fresh round.
        cur   = 0;
        blk_d = {$urandom, $urandom, $urandom, $urandom};
        send(0, blk_d, fips_key, 1'b0);
        tick();
        check("sbox_step1_word", sbw_mon[0], 128'(blk_d[95:64]));
        reset = 1'b1;
        #1;
        check("midreset_out_valid", 128'(out_valid[0]), 128'd0);
        check("midreset_block_o", block_o[0], 128'd0);
        check("midreset_sboxw_i", sbw_mon[0], 128'd0);
        check("midreset_in_ready", 128'(in_ready[0]), 128'd1);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        send(0, fips_in, fips_key, 1'b0);
        wait_out(0, "post_reset_latency");
        check("post_reset_answer", block_o[0], fips_out);
        tick();

        // Random rounds across all lane counts.
        for (int k = 0; k < 6; k++) begin
            cur   = k % 3;
            blk_a = {$urandom, $urandom, $urandom, $urandom};
            key_a = {$urandom, $urandom, $urandom, $urandom};
            fin_r = 1'($urandom_range(0, 1));
            send(cur, blk_a, key_a, fin_r);
            wait_out(cur, "random_latency");
            tick();
        end

        tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_enc_round_lanes.md
# aes_enc_round_lanes

Parametrised AES encryption round engine for the SNOW-V datapath, the next generation of our single-lane round block. It time-multiplexes SubBytes over an external combinational S-box bank of NUM_LANES 32-bit words per cycle, then applies ShiftRows, an optional MixColumns and AddRoundKey in one cycle. Blocks and keys are latched at acceptance, so upstream need not hold them. Valid/ready handshakes on both sides allow back-to-back rounds.

## Interface
- NUM_LANES, 1, S-box words substituted per cycle; legal values 1, 2, 4; others are an elaboration error.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  block_i, round_key and final_round are valid.
- in_ready  out  1  engine can accept; (state==IDLE) || (state==DONE && out_ready).
- block_i  in  128  input state; word 0 = bits 127:96.
- round_key  in  128  round key, latched with block_i.
- final_round  in  1  1 = omit MixColumns (AES last round).
- sboxw_i  out  32*NUM_LANES  words to S-box bank; lane k = bits [32*(NUM_LANES-k)-1 -: 32].
- sboxw_o  in  32*NUM_LANES  substituted words, same lane order, same cycle.
- block_o  out  128  round result; stable while out_valid.
- out_valid  out  1  block_o holds a completed round.
- out_ready  in  1  downstream accepts block_o.

## Operation
- States: IDLE, SBOX, MAIN, DONE. S = 4/NUM_LANES SubBytes steps.
- IDLE: in_ready=1. When in_valid, latch block_i, round_key and final_round into state/key/mode registers, clear step_ctr, go to SBOX.
- SBOX: sboxw_i = state words step_ctr*NUM_LANES .. +NUM_LANES-1. Write sboxw_o back into those words and increment step_ctr. After step S-1, go to MAIN.
- MAIN: state <= AddRoundKey(MixColumns?(ShiftRows(state)), key). MixColumns is skipped when mode=1. Set out_valid and go to DONE.
- DONE: hold block_o and out_valid until out_ready. On out_ready with in_valid, clear out_valid, latch the new input and go to SBOX; this is back-to-back and carries no idle cycle. On out_ready without in_valid, go to IDLE.
- sboxw_i is 0 outside SBOX. block_o = state register.
- GF(2^8) arithmetic uses polynomial 0x11B, with xtime = {b[6:0],0} ^ (0x1B & {8{b[7]}}).

## Timing
- Reset values: out_valid=0, block_o=0, sboxw_i=0, state=IDLE (so in_ready=1), step_ctr=0, key/mode=0.
- Latency: out_valid rises S+1 edges after the accept edge. This is 5 edges for NUM_LANES=1, 3 for 2 and 2 for 4.
- Throughput: one round per S+1 cycles with a continuously ready sink.
- in_ready depends combinationally on out_ready. The downstream side must not make out_ready depend on in_ready.
- Inputs are sampled only on the accept edge. Changes to them during SBOX/MAIN/DONE have no effect.
- in_valid in SBOX/MAIN is ignored (in_ready=0); no data loss, because upstream holds the data per the handshake.
- Reset asserted mid-operation: the in-flight round is discarded and all registers take their reset values immediately. Operation restarts from IDLE after deassertion.
- out_valid stays high through an arbitrarily long out_ready=0 stall, and block_o stays unchanged.

## Configuration
- AES_ROUND_FINAL_EN defined: final_round is latched and honoured as above.
- AES_ROUND_FINAL_EN undefined: final_round is ignored and the mode register is removed. MixColumns is always applied (SNOW-V keystream rounds only).

## Structure
- Package aes_round_pkg holds:
  - the state enum (IDLE/SBOX/MAIN/DONE);
  - the xtime/gm2/gm3 functions, mixw, shiftrows and mixcolumns;
  - the AES_WORDS=4 constant.
- One combinational sub-module, aes_mixcolumns, computes MixColumns on 128 bits. The FSM, counter and registers stay in aes_enc_round_lanes.

## Test plan
- FIPS-197 B round 1: block_i=193de3bea0f4e22b9ac68d2ae9f84808, key=a0fafe1788542cb123a339392a6c7605, final_round=0 -> block_o=a49c7ff2689f352b6b5bea43026a5049, with out_valid at edge S+1, for NUM_LANES 1, 2 and 4.
- Final round, macro defined: block_i=eb598b1b402ea1c3f23813421e84e7d2, key=d014f9a8c9ee2589e13f0cc8b6630ca6, final_round=1 -> block_o=3925841d02dc09fbdc118597196a0b32. With macro undefined, the same stimulus must produce the MixColumns result instead.
- Back-to-back: in_valid held with out_ready=1 -> second accept on the same edge as the first output handshake. Expect out_valid pulses spaced S+1 cycles apart and correct results for both.
- Stall: out_ready=0 for 10 cycles -> out_valid and block_o constant, in_ready=0, and new in_valid with changed block_i has no effect.
- Reset pulse during SBOX step 1 (NUM_LANES=1) -> out_valid=0, block_o=0 and sboxw_i=0 immediately. A fresh round after release gives the correct result.
- Input change after accept: flip block_i/round_key the cycle after acceptance -> output equals the latched-input result.
